// File: rtl/bf_pkg.sv
// Shared definitions for the data memory controller.
// Holds the operation opcodes, the controller FSM state encoding and a
// helper that says which opcodes modify the current cell.
package bf_pkg;

  // Opcode 7 is reserved and behaves as NOP.
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_INC   = 3'd1,
    OP_DEC   = 3'd2,
    OP_RIGHT = 3'd3,
    OP_LEFT  = 3'd4,
    OP_OUT   = 3'd5,
    OP_IN    = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  // True for opcodes whose EXEC cycle writes the current cell.
  function automatic logic op_writes(op_e o);
    return (o == OP_INC) || (o == OP_DEC) || (o == OP_IN);
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous RAM holding the data cells.
// Ports:
//   clk   - clock, read and write on rising edge
//   we    - write enable
//   addr  - cell address
//   wdata - write data
//   rdata - registered read data (write-first: shows wdata on a write)
// INIT_RAM != 0 starts every cell at zero; otherwise contents are undefined.
// There is deliberately no reset: cell contents survive controller resets.
module data_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int INIT_RAM   = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (INIT_RAM != 0) begin : g_init
      logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};

      always_ff @(posedge clk) begin
        if (we) begin
          mem[addr] <= wdata;
          rdata     <= wdata;
        end else begin
          rdata     <= mem[addr];
        end
      end
    end else begin : g_noinit
      logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

      always_ff @(posedge clk) begin
        if (we) begin
          mem[addr] <= wdata;
          rdata     <= wdata;
        end else begin
          rdata     <= mem[addr];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: a pointer into a cell RAM plus a small FSM that
// executes one cell/pointer operation at a time.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   op_valid    - requester presents op/op_data (held until accepted)
//   op          - opcode (see bf_pkg::op_e)
//   op_data     - value stored by IN
//   op_ready    - high in IDLE only; accept = op_valid && op_ready
//   done        - one-cycle pulse after EXEC; results visible
//   cell_value  - RAM read data for the cell at pointer
//   cell_zero   - cell_value == 0
//   pointer     - current data pointer
// Flow: accept at edge N (pointer moves here for RIGHT/LEFT), EXEC for one
// cycle, edge N+1 writes/reads the cell and returns to IDLE with done=1.
module data_mem_ctrl
  import bf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int INIT_RAM   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] op_data,
  output logic                  op_ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] cell_value,
  output logic                  cell_zero,
  output logic [ADDR_WIDTH-1:0] pointer
);

  state_e                state;
  op_e                   op_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;

  assign op_ready  = (state == ST_IDLE);
  assign cell_zero = (cell_value == '0);

  // Write enable is decoded from the state register, so an asynchronous
  // reset during EXEC drops it before the next edge and the write is lost.
  assign ram_we = (state == ST_EXEC) && op_writes(op_r);

  // cell_value in EXEC still holds the current cell: the accept edge read
  // it, and INC/DEC/IN never move the pointer.
  always_comb begin
    ram_wdata = data_r;
    case (op_r)
      OP_INC:  ram_wdata = cell_value + DATA_WIDTH'(1);
      OP_DEC:  ram_wdata = cell_value - DATA_WIDTH'(1);
      default: ram_wdata = data_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_PRIME;
      pointer <= '0;
      done    <= 1'b0;
      op_r    <= OP_NOP;
      data_r  <= '0;
    end else begin
      case (state)
        // One read cycle so cell_value is valid before the first accept.
        ST_PRIME: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_IDLE: begin
          done <= 1'b0;
          if (op_valid) begin
            op_r   <= op_e'(op);
            data_r <= op_data;
            state  <= ST_EXEC;
            // Moving the pointer at accept lets EXEC read the new cell.
            case (op_e'(op))
              OP_RIGHT: pointer <= pointer + ADDR_WIDTH'(1);
              OP_LEFT:  pointer <= pointer - ADDR_WIDTH'(1);
              default:  pointer <= pointer;
            endcase
          end
        end
        ST_EXEC: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= ST_PRIME;
        end
      endcase
    end
  end

  data_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_RAM   (INIT_RAM)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (pointer),
    .wdata (ram_wdata),
    .rdata (cell_value)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: the driver pushes hand-computed
// expectations as it issues operations; a monitor pops and compares on
// every done pulse, including the accept-to-done cycle count.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [7:0]  op_data = 8'd0;
  logic        op_ready;
  logic        done;
  logic [7:0]  cell_value;
  logic        cell_zero;
  logic [14:0] pointer;

  localparam logic [2:0] NOP = 3'd0, INC = 3'd1, DEC = 3'd2, RIGHT = 3'd3,
                         LEFT = 3'd4, OUT = 3'd5, IN = 3'd6, RSVD = 3'd7;

  data_mem_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(15), .INIT_RAM(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op         (op),
    .op_data    (op_data),
    .op_ready   (op_ready),
    .done       (done),
    .cell_value (cell_value),
    .cell_zero  (cell_zero),
    .pointer    (pointer)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  val;
    logic [14:0] ptr;
    int          at;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("cell_value", {24'd0, cell_value}, {24'd0, e.val});
          check("cell_zero", {31'd0, cell_zero}, {31'd0, (e.val == 8'd0)});
          check("pointer", {17'd0, pointer}, {17'd0, e.ptr});
          check("done_cycle", cyc, e.at);
        end
      end
    end
  end

  // Issue one op when op_ready; done is expected two edges after the drive point.
  task automatic issue(input logic [2:0] o, input logic [7:0] d,
                       input logic [7:0] ev, input logic [14:0] ep);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!op_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!op_ready) begin
      total++;
      bad++;
      $display("FAIL op_ready_timeout: got op_ready=0 want 1 within 50 cycles");
      return;
    end
    op_valid = 1'b1;
    op       = o;
    op_data  = d;
    e.val = ev;
    e.ptr = ep;
    e.at  = cyc + 2;
    sb.push_back(e);
    @(negedge clk);
    op_valid = 1'b0;
    op       = NOP;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int c0;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_op_ready", {31'd0, op_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pointer", {17'd0, pointer}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("prime_op_ready", {31'd0, op_ready}, 32'd1);
    check("prime_done", {31'd0, done}, 32'd0);
    check("prime_cell", {24'd0, cell_value}, 32'd0);

    // IN / OUT
    issue(IN,  8'h41, 8'h41, 15'h0000);
    issue(OUT, 8'h00, 8'h41, 15'h0000);
    // Data wrap both ways
    issue(IN,  8'hFF, 8'hFF, 15'h0000);
    issue(INC, 8'h00, 8'h00, 15'h0000);
    issue(DEC, 8'h00, 8'hFF, 15'h0000);
    // Pointer wrap both ways
    issue(LEFT,  8'h00, 8'h00, 15'h7FFF);
    issue(RIGHT, 8'h00, 8'hFF, 15'h0000);
    // Cell independence
    issue(IN,    8'h05, 8'h05, 15'h0000);
    issue(RIGHT, 8'h00, 8'h00, 15'h0001);
    issue(IN,    8'h09, 8'h09, 15'h0001);
    issue(LEFT,  8'h00, 8'h05, 15'h0000);
    issue(RIGHT, 8'h00, 8'h09, 15'h0001);
    // NOP and reserved opcode leave everything alone; IN data ignored by NOP
    issue(NOP,  8'hAA, 8'h09, 15'h0001);
    issue(RSVD, 8'hBB, 8'h09, 15'h0001);
    issue(LEFT, 8'h00, 8'h05, 15'h0000);
    drain();

    // op_valid held high with INC: accepted every second cycle.
    @(negedge clk);
    op_valid = 1'b1;
    op       = INC;
    c0       = cyc;
    for (int k = 1; k <= 10; k++) begin
      exp_t e;
      e.val = 8'(5 + k);
      e.ptr = 15'h0000;
      e.at  = c0 + 2 * k;
      sb.push_back(e);
    end
    repeat (20) @(negedge clk);
    op_valid = 1'b0;
    op       = NOP;
    drain();
    repeat (3) @(negedge clk);

    // Reset during EXEC aborts the write; RAM contents retained.
    issue(IN, 8'h33, 8'h33, 15'h0000);
    drain();
    op_valid = 1'b1;
    op       = IN;
    op_data  = 8'h77;
    @(negedge clk);
    op_valid = 1'b0;
    op       = NOP;
    check("exec_before_abort", {31'd0, op_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_op_ready", {31'd0, op_ready}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_pointer", {17'd0, pointer}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_ready", {31'd0, op_ready}, 32'd1);
    check("after_rst_cell", {24'd0, cell_value}, 32'h33);
    check("after_rst_pointer", {17'd0, pointer}, 32'd0);
    issue(OUT, 8'h00, 8'h33, 15'h0000);
    issue(INC, 8'h00, 8'h34, 15'h0000);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the cell width in bits.
REQ-002 Parameter ADDR_WIDTH, default 15, SHALL set the data pointer width (2^ADDR_WIDTH cells).
REQ-003 Parameter INIT_RAM, default 1, SHALL be passed unchanged to the data_ram instance.
REQ-004 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 op_valid  input  1  requester has an operation on op/op_data.
REQ-007 op  input  3  opcode: NOP=0, INC=1, DEC=2, RIGHT=3, LEFT=4, OUT=5, IN=6; 7 SHALL be treated as NOP.
REQ-008 op_data  input  DATA_WIDTH  value to store for IN; ignored otherwise.
REQ-009 op_ready  output  1  controller can accept an operation this cycle.
REQ-010 done  output  1  one-cycle pulse: previous operation complete, results visible.
REQ-011 cell_value  output  DATA_WIDTH  contents of the cell at pointer (RAM data_out).
REQ-012 cell_zero  output  1  cell_value == 0, for loop decisions.
REQ-013 pointer  output  ADDR_WIDTH  current data pointer.

Function
REQ-014 FSM states SHALL be PRIME, IDLE, EXEC; op_ready SHALL be 1 only in IDLE.
REQ-015 RAM address SHALL always equal pointer; RAM write SHALL be 1 only in EXEC for INC, DEC, IN.
REQ-016 PRIME: RAM read of pointer for one cycle, then IDLE with done=0.
REQ-017 Accept = op_valid && op_ready at edge N; op and op_data SHALL be registered at edge N; IDLE -> EXEC.
REQ-018 EXEC SHALL last exactly one cycle; at edge N+1 -> IDLE with done=1 for that one IDLE cycle.
REQ-019 Latency accept-to-done SHALL be 1 cycle (two edges) for every opcode; peak throughput one op per 2 cycles.
REQ-020 INC/DEC: EXEC writes cell_value +/- 1 modulo 2^DATA_WIDTH (255+1=0, 0-1=255).
REQ-021 IN: EXEC writes registered op_data to the current cell.
REQ-022 RIGHT/LEFT: pointer SHALL update at edge N, +/- 1 modulo 2^ADDR_WIDTH (wrap both ways); EXEC reads the new cell.
REQ-023 OUT, NOP, opcode 7: EXEC performs a read only; pointer and memory unchanged.
REQ-024 In IDLE, cell_value/cell_zero SHALL reflect the cell at pointer, including immediately after every done.
REQ-025 op_valid outside IDLE SHALL be ignored; the requester holds op until accepted.
REQ-026 done and op_ready SHALL both be 1 in the done cycle; a new op may be accepted in that cycle.

Reset
REQ-027 While rst_n=0: state=PRIME, pointer=0, done=0, op_ready=0, RAM write=0, all asynchronously.
REQ-028 After rst_n deasserts: first edge performs PRIME read of cell 0; op_ready=1 from the following cycle.
REQ-029 Reset during EXEC SHALL abort the write (write enable low before the next edge); RAM contents SHALL NOT be cleared.
REQ-030 cell_value after reset SHALL be the retained RAM contents of cell 0, not forced to 0.

Structure
REQ-031 Shared package bf_pkg SHALL hold opcode constants and FSM state encodings.
REQ-032 One sub-module: data_ram, instanced once with DATA_WIDTH, ADDR_WIDTH, INIT_RAM passed through.
REQ-033 Datapath (pointer register, +/-1 adders, write mux) and FSM SHALL live in data_mem_ctrl.

Verification
REQ-034 Reset, then IN 0x41, OUT -> done after 2 edges each; cell_value=0x41, cell_zero=0, pointer=0.
REQ-035 IN 0xFF, INC -> cell_value=0x00, cell_zero=1; then DEC -> 0xFF.
REQ-036 LEFT from pointer 0 -> pointer=0x7FFF, cell_value=0; RIGHT -> pointer=0, cell_value=previous cell 0.
REQ-037 IN 5 at ptr 0, RIGHT, IN 9, LEFT -> cell_value=5; RIGHT -> 9 (cells independent).
REQ-038 op_valid held high continuously with INC -> accepts every 2nd cycle; 10 INCs -> cell +10.
REQ-039 Write 0x33 to cell 0, assert rst_n=0 during EXEC of IN 0x77, release -> after PRIME cell_value=0x33, pointer=0.
